// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter.
//   op_e             : operation selected by the priority decode each cycle
//   WIDTH_MIN/MAX    : legal range of the counter width parameter
package counter_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_DEC  = 2'd2,
        OP_INC  = 2'd3
    } op_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_is_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/counter_next_logic.sv
// Combinational next-state function of the up/down counter.
// Ports:
//   op          : decoded operation for this cycle
//   value       : current count
//   reload      : stored reload value (last latched load)
//   load_value  : value presented for a load
//   value_next  : count after the coming edge
//   expire_next : expire flag to register on the coming edge
module counter_next_logic
    import counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter bit SATURATE    = 1'b1,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] reload,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value_next,
    output logic             expire_next
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    always_comb begin
        value_next  = value;
        expire_next = 1'b0;
        case (op)
            OP_LOAD: begin
                // A load never expires, even a load of zero.
                value_next = load_value;
            end
            OP_DEC: begin
                if (value != '0) begin
                    value_next  = value - ONE;
                    expire_next = (value == ONE);
                end else if (AUTO_RELOAD) begin
                    value_next  = reload;
                    expire_next = 1'b1;
                end else if (SATURATE) begin
                    value_next = '0;
                end else begin
                    value_next = ALL_ONES;
                end
            end
            OP_INC: begin
                // Auto-reload deliberately plays no part when counting up.
                if (value != ALL_ONES) begin
                    value_next = value + ONE;
                end else if (SATURATE) begin
                    value_next = ALL_ONES;
                end else begin
                    value_next = '0;
                end
            end
            default: begin
                value_next = value;
            end
        endcase
    end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with load, optional saturation and optional auto-reload.
// Ports:
//   clock  : sole clock, rising edge
//   reset  : synchronous active-high reset
//   in     : load value
//   latch  : load request (highest priority after reset)
//   dec    : decrement request
//   inc    : increment request (inc and dec together hold)
//   value  : current count, straight from the register
//   zero   : value == 0, decoded from the register
//   max    : value == all ones, decoded from the register
//   expire : registered one-cycle pulse after a dec reaches 0 or reloads
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter bit SATURATE    = 1'b1,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             latch,
    input  logic             dec,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             zero,
    output logic             max,
    output logic             expire
);

    generate
        if (!width_is_legal(WIDTH)) begin : g_bad_width
            $error("updown_counter: WIDTH must be within 2..32");
        end
    endgenerate

    logic [WIDTH-1:0] value_reg;
    logic [WIDTH-1:0] reload_reg;
    logic             expire_reg;
    logic [WIDTH-1:0] value_next;
    logic             expire_next;
    op_e              op;

    // Priority: latch > (inc & dec) > dec > inc > hold.
    always_comb begin
        op = OP_HOLD;
        if (latch) begin
            op = OP_LOAD;
        end else if (inc && dec) begin
            op = OP_HOLD;
        end else if (dec) begin
            op = OP_DEC;
        end else if (inc) begin
            op = OP_INC;
        end
    end

    counter_next_logic #(
        .WIDTH       (WIDTH),
        .SATURATE    (SATURATE),
        .AUTO_RELOAD (AUTO_RELOAD)
    ) u_next (
        .op          (op),
        .value       (value_reg),
        .reload      (reload_reg),
        .load_value  (in),
        .value_next  (value_next),
        .expire_next (expire_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            value_reg  <= '0;
            reload_reg <= '0;
            expire_reg <= 1'b0;
        end else begin
            value_reg  <= value_next;
            expire_reg <= expire_next;
            if (op == OP_LOAD) begin
                reload_reg <= in;
            end
        end
    end

    assign value  = value_reg;
    assign expire = expire_reg;
    assign zero   = (value_reg == '0);
    assign max    = (value_reg == {WIDTH{1'b1}});

endmodule

// File: tb/tb_updown_counter.sv
module tb_updown_counter;

    typedef struct {
        int         d;
        logic [7:0] v;
        logic       e;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s   [4];
    logic       latch_s [4];
    logic       dec_s   [4];
    logic       inc_s   [4];
    logic [7:0] in_s    [4];

    logic [7:0] obs_v [4];
    logic       obs_z [4];
    logic       obs_m [4];
    logic       obs_e [4];

    logic [3:0] v0, v1, v2;
    logic [7:0] v3;

    // dut0: saturating, dut1: wrapping, dut2: saturating + auto-reload, dut3: 8-bit wrapping
    updown_counter #(.WIDTH(4), .SATURATE(1'b1), .AUTO_RELOAD(1'b0)) dut0 (
        .clock(clk), .reset(rst_s[0]), .in(in_s[0][3:0]), .latch(latch_s[0]),
        .dec(dec_s[0]), .inc(inc_s[0]), .value(v0), .zero(obs_z[0]),
        .max(obs_m[0]), .expire(obs_e[0]));
    updown_counter #(.WIDTH(4), .SATURATE(1'b0), .AUTO_RELOAD(1'b0)) dut1 (
        .clock(clk), .reset(rst_s[1]), .in(in_s[1][3:0]), .latch(latch_s[1]),
        .dec(dec_s[1]), .inc(inc_s[1]), .value(v1), .zero(obs_z[1]),
        .max(obs_m[1]), .expire(obs_e[1]));
    updown_counter #(.WIDTH(4), .SATURATE(1'b1), .AUTO_RELOAD(1'b1)) dut2 (
        .clock(clk), .reset(rst_s[2]), .in(in_s[2][3:0]), .latch(latch_s[2]),
        .dec(dec_s[2]), .inc(inc_s[2]), .value(v2), .zero(obs_z[2]),
        .max(obs_m[2]), .expire(obs_e[2]));
    updown_counter #(.WIDTH(8), .SATURATE(1'b0), .AUTO_RELOAD(1'b0)) dut3 (
        .clock(clk), .reset(rst_s[3]), .in(in_s[3]), .latch(latch_s[3]),
        .dec(dec_s[3]), .inc(inc_s[3]), .value(v3), .zero(obs_z[3]),
        .max(obs_m[3]), .expire(obs_e[3]));

    assign obs_v[0] = {4'h0, v0};
    assign obs_v[1] = {4'h0, v1};
    assign obs_v[2] = {4'h0, v2};
    assign obs_v[3] = v3;

    // Drive one cycle of requests on DUT d, queue the expected result,
    // then compare it just after the edge.
    task automatic step(input int d, input bit r, input bit l, input bit dc, input bit ic,
                        input logic [7:0] din, input logic [7:0] ev, input bit ee,
                        input string tag);
        exp_t       e;
        logic [7:0] mask;
        @(negedge clk);
        rst_s[d]   = r;
        latch_s[d] = l;
        dec_s[d]   = dc;
        inc_s[d]   = ic;
        in_s[d]    = din;
        e.d = d; e.v = ev; e.e = ee; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst_s[d] = 1'b0; latch_s[d] = 1'b0; dec_s[d] = 1'b0; inc_s[d] = 1'b0;
        e    = sb.pop_front();
        mask = (e.d == 3) ? 8'hFF : 8'h0F;
        $display("step %-14s dut%0d value=%0d zero=%0b max=%0b expire=%0b",
                 e.tag, e.d, obs_v[e.d], obs_z[e.d], obs_m[e.d], obs_e[e.d]);
        checks++;
        assert (obs_v[e.d] === e.v) else begin
            failures++;
            $error("FAIL %s value got=%0d exp=%0d", e.tag, obs_v[e.d], e.v);
        end
        checks++;
        assert (obs_e[e.d] === e.e) else begin
            failures++;
            $error("FAIL %s expire got=%0b exp=%0b", e.tag, obs_e[e.d], e.e);
        end
        checks++;
        assert (obs_z[e.d] === (e.v == 8'h00)) else begin
            failures++;
            $error("FAIL %s zero got=%0b exp=%0b", e.tag, obs_z[e.d], (e.v == 8'h00));
        end
        checks++;
        assert (obs_m[e.d] === (e.v == mask)) else begin
            failures++;
            $error("FAIL %s max got=%0b exp=%0b", e.tag, obs_m[e.d], (e.v == mask));
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst_s[i] = 1'b0; latch_s[i] = 1'b0; dec_s[i] = 1'b0;
            inc_s[i] = 1'b0; in_s[i] = 8'h00;
        end

        // reset state of every instance
        for (int i = 0; i < 4; i++) step(i, 1, 0, 0, 0, 8'd0, 8'd0, 0, "reset");

        // count down to zero: expire pulses once
        step(0, 0, 1, 0, 0, 8'd3, 8'd3, 0, "load3");
        step(0, 0, 0, 1, 0, 8'd0, 8'd2, 0, "dec_2");
        step(0, 0, 0, 1, 0, 8'd0, 8'd1, 0, "dec_1");
        step(0, 0, 0, 1, 0, 8'd0, 8'd0, 1, "dec_0_expire");
        step(0, 0, 0, 0, 0, 8'd0, 8'd0, 0, "hold_0");

        // saturation at both ends
        step(0, 0, 0, 1, 0, 8'd0, 8'd0, 0, "sat_dec_a");
        step(0, 0, 0, 1, 0, 8'd0, 8'd0, 0, "sat_dec_b");
        step(0, 0, 1, 0, 0, 8'd15, 8'd15, 0, "load15");
        step(0, 0, 0, 0, 1, 8'd0, 8'd15, 0, "sat_inc");

        // priority: latch over inc&dec, inc&dec holds, reset over dec
        step(0, 0, 1, 0, 0, 8'd5, 8'd5, 0, "load5");
        step(0, 0, 1, 1, 1, 8'd9, 8'd9, 0, "load9_incdec");
        step(0, 0, 0, 1, 1, 8'd0, 8'd9, 0, "incdec_hold");
        step(0, 1, 0, 1, 0, 8'd0, 8'd0, 0, "reset_dec");
        step(0, 0, 0, 1, 0, 8'd0, 8'd0, 0, "post_reset");

        // latch beats dec at value 1; no expire
        step(0, 0, 1, 0, 0, 8'd1, 8'd1, 0, "load1");
        step(0, 0, 1, 1, 0, 8'd4, 8'd4, 0, "load4_dec");
        step(0, 0, 0, 0, 1, 8'd0, 8'd5, 0, "inc_5");

        // wrap mode
        step(1, 0, 0, 1, 0, 8'd0, 8'd15, 0, "wrap_dec");
        step(1, 0, 0, 0, 1, 8'd0, 8'd0, 0, "wrap_inc");
        step(1, 0, 0, 0, 1, 8'd0, 8'd1, 0, "wrap_inc1");

        // auto-reload
        step(2, 0, 1, 0, 0, 8'd2, 8'd2, 0, "ar_load2");
        step(2, 0, 0, 1, 0, 8'd0, 8'd1, 0, "ar_dec1");
        step(2, 0, 0, 1, 0, 8'd0, 8'd0, 1, "ar_dec0");
        step(2, 0, 0, 1, 0, 8'd0, 8'd2, 1, "ar_reload");
        step(2, 0, 0, 1, 0, 8'd0, 8'd1, 0, "ar_dec1b");
        step(2, 0, 1, 0, 0, 8'd7, 8'd7, 0, "ar_load7");
        step(2, 1, 0, 0, 1, 8'd0, 8'd0, 0, "ar_reset_inc");
        step(2, 0, 0, 1, 0, 8'd0, 8'd0, 1, "ar_reload0");

        // 8-bit wrap
        step(3, 0, 1, 0, 0, 8'd255, 8'd255, 0, "w8_load255");
        step(3, 0, 0, 0, 1, 8'd0, 8'd0, 0, "w8_inc_wrap");
        step(3, 0, 0, 1, 0, 8'd0, 8'd255, 0, "w8_dec_wrap");
        step(3, 0, 1, 0, 0, 8'd100, 8'd100, 0, "w8_load100");
        step(3, 0, 0, 0, 1, 8'd0, 8'd101, 0, "w8_inc");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter SATURATE, default 1: 1 = clamp at 0 / max, 0 = wrap modulo 2^WIDTH.
REQ-003 Parameter AUTO_RELOAD, default 0: 1 = decrement at zero reloads the stored load value.
REQ-004 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port in  input  WIDTH  load value.
REQ-007 Port latch  input  1  load request.
REQ-008 Port dec  input  1  decrement request.
REQ-009 Port inc  input  1  increment request.
REQ-010 Port value  output  WIDTH  current count, driven directly from the register.
REQ-011 Port zero  output  1  high when value == 0; combinational from the register.
REQ-012 Port max  output  1  high when value == 2^WIDTH-1; combinational from the register.
REQ-013 Port expire  output  1  registered one-cycle pulse.

Function
REQ-014 Per-cycle priority SHALL be: reset > latch > (inc & dec) > dec > inc > hold.
REQ-015 latch SHALL load in into value and into the internal reload register on the same edge.
REQ-016 inc and dec both high without latch SHALL hold value; neither edge counts.
REQ-017 dec with value > 0 SHALL give value-1 on the next edge.
REQ-018 dec with value == 0 SHALL give the reload register if AUTO_RELOAD=1; else hold 0 if SATURATE=1; else 2^WIDTH-1.
REQ-019 inc with value < max SHALL give value+1 on the next edge.
REQ-020 inc with value == max SHALL hold max if SATURATE=1; else give 0. AUTO_RELOAD has no effect on inc.
REQ-021 expire SHALL be high for exactly the one cycle after an edge where a dec moved value from 1 to 0.
REQ-022 expire SHALL also be high for the one cycle after an AUTO_RELOAD reload edge.
REQ-023 expire SHALL NOT assert on a latch of 0, on a wrap to 0 by inc, or while dec holds a saturated 0.
REQ-024 A latch in the same cycle as dec at value 1 SHALL take the load; expire stays low.
REQ-025 All arithmetic SHALL be WIDTH bits, with no carry/borrow outputs.
REQ-026 zero and max SHALL both be derived from the register and SHALL have no input-to-output combinational path.
REQ-027 Latency from any request to the value update SHALL be one clock; expire follows its cause by one clock.

Reset
REQ-028 reset SHALL set value=0, reload register=0, expire=0; zero=1 and max=0 follow from this.
REQ-029 reset asserted during counting SHALL take effect on the next edge and discard any same-cycle latch, inc or dec.
REQ-030 On the first cycle after reset deasserts, no expire SHALL be generated.

Structure
REQ-031 Shared package counter_pkg SHALL hold the op enum (OP_HOLD, OP_LOAD, OP_DEC, OP_INC) and the WIDTH legality check constants.
REQ-032 Sub-module counter_next_logic SHALL map (op, value, reload, parameters) to next value and an expire_next flag, purely combinationally.
REQ-033 The top level SHALL contain the priority decode, the value, reload and expire registers, and the flag logic.

Verification (WIDTH=4 unless stated)
REQ-034 reset, latch in=3, then dec x3 -> value 3,2,1,0; zero=1 at 0; expire pulses once in the cycle after value reaches 0.
REQ-035 SATURATE=1: value 0, dec x2 -> value stays 0, expire stays 0; latch in=15, inc -> value 15, max=1.
REQ-036 SATURATE=0: value 0, dec -> 15; then inc -> 0; expire stays 0 throughout.
REQ-037 AUTO_RELOAD=1: latch 2, then dec x4 -> value 1,0,2,1; expire pulses after the 1->0 edge and after the reload edge.
REQ-038 value 5, latch in=9 with inc=dec=1 -> 9; then inc=dec=1 -> holds 9; then reset with dec=1 -> value 0, expire 0.
REQ-039 WIDTH=8, SATURATE=0: latch 255, inc -> 0, zero=1, max=0; dec -> 255, max=1.
